// File: rtl/instr_fetch_module_if.sv
// Fetch-stage bus: control, redirect and program-load inputs plus IF/ID outputs.
interface instr_fetch_module_if #(
    parameter int unsigned NB_BITS = 32,
    parameter int unsigned NB_JMP  = 26,
    parameter int unsigned NB_ADDR = 10
);
    logic                i_start;
    logic                i_stall;
    logic                i_pc_src;
    logic [NB_JMP-1:0]   i_jmp_addr;
    logic                i_pc_beq;
    logic [NB_BITS-1:0]  i_brh_addr;
    logic                i_flush;
    logic                i_prog_wenb;
    logic [NB_ADDR-1:0]  i_prog_addr;
    logic [NB_BITS-1:0]  i_prog_data;
    logic [NB_BITS-1:0]  o_if_id_pc;
    logic [NB_BITS-1:0]  o_if_id_instr;
    logic [NB_BITS-1:0]  o_pc;
    logic                o_halt;
    logic                o_running;

    // Pipeline / loader side drives the fetch stage.
    modport master (
        output i_start, i_stall, i_pc_src, i_jmp_addr, i_pc_beq, i_brh_addr, i_flush,
        output i_prog_wenb, i_prog_addr, i_prog_data,
        input  o_if_id_pc, o_if_id_instr, o_pc, o_halt, o_running
    );

    // Fetch stage itself.
    modport slave (
        input  i_start, i_stall, i_pc_src, i_jmp_addr, i_pc_beq, i_brh_addr, i_flush,
        input  i_prog_wenb, i_prog_addr, i_prog_data,
        output o_if_id_pc, o_if_id_instr, o_pc, o_halt, o_running
    );
endinterface

// File: rtl/instr_fetch_module.sv
// Instruction fetch stage: PC register, instruction memory with program-load
// port, IF/ID pipeline latch and an IDLE/RUN/HALT control FSM.
module instr_fetch_module #(
    parameter int unsigned NB_BITS = 32,
    parameter int unsigned NB_JMP  = 26,
    parameter int unsigned NB_ADDR = 10,
    parameter logic [5:0]  HALT_OP = 6'b111111
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    instr_fetch_module_if.slave   bus
);
    localparam int unsigned MEM_DEPTH = 1 << NB_ADDR;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StHalt = 2'b10
    } state_e;

    state_e              state_q, state_d;
    logic [NB_BITS-1:0]  pc_q, pc_d;
    logic [NB_BITS-1:0]  if_id_pc_q, if_id_pc_d;
    logic [NB_BITS-1:0]  if_id_instr_q, if_id_instr_d;
    logic [NB_BITS-1:0]  mem [MEM_DEPTH];

    logic [NB_BITS-1:0]  fetch_instr;
    logic [NB_BITS-1:0]  pc_plus4;
    logic [NB_BITS-1:0]  jmp_target;
    logic                redirect;
    logic                halt_hit;

    // Upper PC bits beyond the memory index are ignored, so fetch wraps.
    assign fetch_instr = mem[pc_q[NB_ADDR+1:2]];
    assign pc_plus4    = pc_q + NB_BITS'(4);
    assign jmp_target  = {pc_plus4[NB_BITS-1:NB_JMP], bus.i_jmp_addr};
    assign redirect    = bus.i_pc_src | bus.i_pc_beq;
    // A flushed or redirected halt word is on a dead path and must not stop fetch.
    assign halt_hit    = (fetch_instr[NB_BITS-1 -: 6] == HALT_OP) && !bus.i_flush && !redirect;

    // Program-load port: writes accepted only while idle; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst && (state_q == StIdle) && bus.i_prog_wenb) begin
            mem[bus.i_prog_addr] <= bus.i_prog_data;
        end
    end

    // State, PC and IF/ID latch registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= StIdle;
            pc_q          <= '0;
            if_id_pc_q    <= '0;
            if_id_instr_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
        end
    end

    // Next-state, next-PC and IF/ID latch selection.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;

        unique case (state_q)
            StIdle: begin
                pc_d          = '0;
                if_id_pc_d    = '0;
                if_id_instr_d = '0;
                if (bus.i_start) begin
                    state_d = StRun;
                end
            end

            StRun: begin
                // Stall freezes everything, overriding flush and redirects.
                if (!bus.i_stall) begin
                    if_id_pc_d    = pc_plus4;
                    if_id_instr_d = bus.i_flush ? '0 : fetch_instr;
                    if (halt_hit) begin
                        state_d = StHalt;
                    end else if (bus.i_pc_src) begin
                        pc_d = jmp_target;
                    end else if (bus.i_pc_beq) begin
                        pc_d = bus.i_brh_addr;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end

            StHalt: begin
                if_id_pc_d    = '0;
                if_id_instr_d = '0;
            end

            default: begin
                state_d       = StIdle;
                pc_d          = '0;
                if_id_pc_d    = '0;
                if_id_instr_d = '0;
            end
        endcase
    end

    assign bus.o_pc          = pc_q;
    assign bus.o_if_id_pc    = if_id_pc_q;
    assign bus.o_if_id_instr = if_id_instr_q;
    assign bus.o_halt        = (state_q == StHalt);
    assign bus.o_running     = (state_q == StRun);
endmodule

// File: tb/tb_instr_fetch_module.sv
// Vector-table bench for instr_fetch_module with a queue-based scoreboard.
module tb_instr_fetch_module;
    localparam int unsigned NB_BITS = 32;
    localparam int unsigned NB_JMP  = 26;
    localparam int unsigned NB_ADDR = 10;

    logic i_clk = 1'b0;
    logic i_rst;

    always #5 i_clk = ~i_clk;

    instr_fetch_module_if #(.NB_BITS(NB_BITS), .NB_JMP(NB_JMP), .NB_ADDR(NB_ADDR)) bus ();

    instr_fetch_module #(
        .NB_BITS (NB_BITS),
        .NB_JMP  (NB_JMP),
        .NB_ADDR (NB_ADDR),
        .HALT_OP (6'b111111)
    ) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    typedef struct {
        logic        rst;
        logic        start;
        logic        stall;
        logic        pc_src;
        logic [25:0] jmp;
        logic        pc_beq;
        logic [31:0] brh;
        logic        flush;
        logic        wenb;
        logic [9:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] e_pc;
        logic [31:0] e_ipc;
        logic        c_ipc;
        logic [31:0] e_instr;
        logic        e_halt;
        logic        e_run;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic vec_t mk(input logic [31:0] e_pc, input logic [31:0] e_ipc,
                                input logic c_ipc, input logic [31:0] e_instr,
                                input logic e_halt, input logic e_run);
        vec_t v;
        v.rst = 1'b0; v.start = 1'b0; v.stall = 1'b0; v.pc_src = 1'b0; v.jmp = '0;
        v.pc_beq = 1'b0; v.brh = '0; v.flush = 1'b0; v.wenb = 1'b0; v.waddr = '0;
        v.wdata = '0; v.e_pc = e_pc; v.e_ipc = e_ipc; v.c_ipc = c_ipc;
        v.e_instr = e_instr; v.e_halt = e_halt; v.e_run = e_run;
        return v;
    endfunction

    task automatic chk(input string what, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", what, idx, act, exp);
    endtask

    task automatic drive(input vec_t v);
        i_rst           = v.rst;
        bus.i_start     = v.start;
        bus.i_stall     = v.stall;
        bus.i_pc_src    = v.pc_src;
        bus.i_jmp_addr  = v.jmp;
        bus.i_pc_beq    = v.pc_beq;
        bus.i_brh_addr  = v.brh;
        bus.i_flush     = v.flush;
        bus.i_prog_wenb = v.wenb;
        bus.i_prog_addr = v.waddr;
        bus.i_prog_data = v.wdata;
    endtask

    // Drive one vector, push its expectation, clock, then pop and compare.
    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        drive(v);
        sb.push_back(v);
        @(posedge i_clk);
        #1;
        e = sb.pop_front();
        chk("pc", idx, bus.o_pc, e.e_pc);
        chk("if_id_instr", idx, bus.o_if_id_instr, e.e_instr);
        chk("halt", idx, 32'(bus.o_halt), 32'(e.e_halt));
        chk("running", idx, 32'(bus.o_running), 32'(e.e_run));
        if (e.c_ipc) chk("if_id_pc", idx, bus.o_if_id_pc, e.e_ipc);
    endtask

    task automatic load(input int addr, input logic [31:0] data);
        vec_t v;
        v = mk(0, 0, 1'b0, 0, 1'b0, 1'b0);
        v.wenb  = 1'b1;
        v.waddr = 10'(addr);
        v.wdata = data;
        drive(v);
        @(posedge i_clk);
        #1;
        bus.i_prog_wenb = 1'b0;
    endtask

    task automatic run_vecs(input int base);
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], base + i);
        vecs.delete();
    endtask

    initial begin
        vec_t t;

        // Reset state.
        t = mk(0, 0, 1'b1, 0, 1'b0, 1'b0);
        t.rst = 1'b1;
        apply(t, 0);
        apply(t, 1);

        // Three-word program ending in a halt word.
        load(0, 32'h2001_0005);
        load(1, 32'h2002_0007);
        load(2, 32'hFC00_0000);

        t = mk(0, 0, 1'b1, 0, 1'b0, 1'b1); t.start = 1'b1; vecs.push_back(t);
        vecs.push_back(mk(32'h4, 32'h4, 1'b1, 32'h2001_0005, 1'b0, 1'b1));
        vecs.push_back(mk(32'h8, 32'h8, 1'b1, 32'h2002_0007, 1'b0, 1'b1));
        vecs.push_back(mk(32'h8, 32'hC, 1'b1, 32'hFC00_0000, 1'b1, 1'b0));
        // Halted: start, jump and program write are all ignored.
        t = mk(32'h8, 0, 1'b0, 0, 1'b1, 1'b0);
        t.start = 1'b1; t.pc_src = 1'b1; t.jmp = 26'h40;
        t.wenb = 1'b1; t.waddr = 10'd0; t.wdata = 32'hFC00_0000;
        vecs.push_back(t);
        // Reset out of HALT.
        t = mk(0, 0, 1'b1, 0, 1'b0, 1'b0); t.rst = 1'b1; vecs.push_back(t);
        vecs.push_back(mk(0, 0, 1'b1, 0, 1'b0, 1'b0));
        // Restart: mem[0] must still be the original word.
        t = mk(0, 0, 1'b1, 0, 1'b0, 1'b1); t.start = 1'b1; vecs.push_back(t);
        vecs.push_back(mk(32'h4, 32'h4, 1'b1, 32'h2001_0005, 1'b0, 1'b1));
        // Reset mid-RUN beats start and discards IF/ID.
        t = mk(0, 0, 1'b1, 0, 1'b0, 1'b0); t.rst = 1'b1; t.start = 1'b1; vecs.push_back(t);
        run_vecs(10);

        // Fill memory for the redirect tests.
        for (int k = 0; k < 128; k++) load(k, 32'h2400_0000 | 32'(k));
        load(20, 32'hFC00_0001);
        load(1023, 32'h2400_03FF);

        t = mk(0, 0, 1'b1, 0, 1'b0, 1'b1); t.start = 1'b1; vecs.push_back(t);
        vecs.push_back(mk(32'h4,  32'h4,  1'b1, 32'h2400_0000, 1'b0, 1'b1));
        vecs.push_back(mk(32'h8,  32'h8,  1'b1, 32'h2400_0001, 1'b0, 1'b1));
        vecs.push_back(mk(32'hC,  32'hC,  1'b1, 32'h2400_0002, 1'b0, 1'b1));
        vecs.push_back(mk(32'h10, 32'h10, 1'b1, 32'h2400_0003, 1'b0, 1'b1));
        // Branch with flush at PC 0x10.
        t = mk(32'h40, 32'h14, 1'b1, 0, 1'b0, 1'b1);
        t.pc_beq = 1'b1; t.brh = 32'h40; t.flush = 1'b1; vecs.push_back(t);
        // Jump and branch together: jump wins.
        t = mk(32'h100, 32'h44, 1'b1, 32'h2400_0010, 1'b0, 1'b1);
        t.pc_src = 1'b1; t.jmp = 26'h100; t.pc_beq = 1'b1; t.brh = 32'h80; vecs.push_back(t);
        // Three stalled cycles with competing redirects/flush.
        for (int s = 0; s < 3; s++) begin
            t = mk(32'h100, 32'h44, 1'b1, 32'h2400_0010, 1'b0, 1'b1);
            t.stall = 1'b1; t.pc_src = 1'b1; t.jmp = 26'h8;
            if (s == 1) t.flush = 1'b1;
            if (s == 2) begin t.pc_beq = 1'b1; t.brh = 32'h200; end
            vecs.push_back(t);
        end
        vecs.push_back(mk(32'h104, 32'h104, 1'b1, 32'h2400_0040, 1'b0, 1'b1));
        // Write of a halt word in RUN must not land.
        t = mk(32'h108, 32'h108, 1'b1, 32'h2400_0041, 1'b0, 1'b1);
        t.wenb = 1'b1; t.waddr = 10'd66; t.wdata = 32'hFC00_0000; vecs.push_back(t);
        vecs.push_back(mk(32'h10C, 32'h10C, 1'b1, 32'h2400_0042, 1'b0, 1'b1));
        t = mk(32'h50, 32'h110, 1'b1, 32'h2400_0043, 1'b0, 1'b1);
        t.pc_beq = 1'b1; t.brh = 32'h50; vecs.push_back(t);
        // Halt word with branch in the same cycle: no halt.
        t = mk(32'h60, 32'h54, 1'b1, 32'hFC00_0001, 1'b0, 1'b1);
        t.pc_beq = 1'b1; t.brh = 32'h60; vecs.push_back(t);
        t = mk(32'h50, 32'h64, 1'b1, 32'h2400_0018, 1'b0, 1'b1);
        t.pc_src = 1'b1; t.jmp = 26'h50; vecs.push_back(t);
        // Halt word with flush: no halt, NOP latched.
        t = mk(32'h54, 32'h54, 1'b1, 0, 1'b0, 1'b1); t.flush = 1'b1; vecs.push_back(t);
        // PC+4 wrap from the top of the address space.
        t = mk(32'hFFFF_FFFC, 32'h58, 1'b1, 32'h2400_0015, 1'b0, 1'b1);
        t.pc_beq = 1'b1; t.brh = 32'hFFFF_FFFC; vecs.push_back(t);
        vecs.push_back(mk(0, 0, 1'b1, 32'h2400_03FF, 1'b0, 1'b1));
        t = mk(32'h50, 32'h4, 1'b1, 32'h2400_0000, 1'b0, 1'b1);
        t.pc_src = 1'b1; t.jmp = 26'h50; vecs.push_back(t);
        // Unredirected halt word halts.
        vecs.push_back(mk(32'h50, 32'h54, 1'b1, 32'hFC00_0001, 1'b1, 1'b0));
        vecs.push_back(mk(32'h50, 0, 1'b0, 0, 1'b1, 1'b0));
        t = mk(32'h50, 0, 1'b0, 0, 1'b1, 1'b0); t.stall = 1'b1; vecs.push_back(t);
        run_vecs(100);

        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
